// File: rtl/aud_pkg.sv
// Shared types for the I2S ADC capture path: sample type, capture FSM states
// and the FIFO entry layout.
package aud_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SKIP    = 2'd1,
    S_RECEIVE = 2'd2,
    S_WAIT    = 2'd3
  } rec_state_t;

  typedef struct packed {
    logic    chan;
    sample_t sample;
  } fifo_entry_t;

endpackage

// File: rtl/aud_recorder_if.sv
// Capture-stage bundle: codec serial inputs plus the downstream valid/ready
// sample stream and overflow status. slave = recorder, master = its user.
interface aud_recorder_if #(
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_CNT_W = 8
);
  import aud_pkg::*;

  logic                          i_en;
  logic                          i_adclrck;
  logic                          i_adcdat;
  logic                          i_ready;
  sample_t                       o_data;
  logic                          o_valid;
  logic                          o_chan;
  logic [$clog2(FIFO_DEPTH):0]   o_level;
  logic                          o_overflow;
  logic [DROP_CNT_W-1:0]         o_drop_cnt;

  modport slave (
    input  i_en, i_adclrck, i_adcdat, i_ready,
    output o_data, o_valid, o_chan, o_level, o_overflow, o_drop_cnt
  );

  modport master (
    output i_en, i_adclrck, i_adcdat, i_ready,
    input  o_data, o_valid, o_chan, o_level, o_overflow, o_drop_cnt
  );

endinterface

// File: rtl/aud_sync_fifo.sv
// First-word-fall-through synchronous FIFO; o_dout is the head entry whenever
// o_empty is low. A push into a full FIFO succeeds only alongside a pop.
module aud_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_wr, w_rd;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_dout  = r_mem[r_rd_ptr];

  assign w_rd = i_pop & ~o_empty;
  assign w_wr = i_push & (~o_full | w_rd);

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/aud_recorder.sv
// I2S ADC capture: deserializes 16-bit MSB-first words after an LRCK edge and
// buffers them in a FWFT FIFO. Define AUD_REC_STEREO_EN to capture right too.
module aud_recorder
  import aud_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_CNT_W = 8
) (
  input  logic          i_bclk,
  input  logic          i_rst,
  aud_recorder_if.slave bus
);
  localparam int CNT_W = $clog2(SAMPLE_W);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
`ifdef AUD_REC_STEREO_EN
  localparam int ENTRY_W = $bits(fifo_entry_t);
`else
  localparam int ENTRY_W = SAMPLE_W;
`endif

  rec_state_t            r_state;
  logic                  r_lrck_q;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [SAMPLE_W-2:0]   r_shift;
  logic                  r_push;
  sample_t               r_push_sample;
  logic                  r_overflow;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic                  w_fall, w_arm, w_wait_done;
  sample_t               w_word, w_head_sample;
  logic [ENTRY_W-1:0]    w_fifo_din, w_fifo_dout;
  logic                  w_full, w_empty, w_pop, w_drop;
  logic [LVL_W-1:0]      w_level;

  assign w_fall = r_lrck_q & ~bus.i_adclrck;
  assign w_word = sample_t'({r_shift, bus.i_adcdat});

`ifdef AUD_REC_STEREO_EN
  logic        r_chan, r_push_chan, w_rise;
  fifo_entry_t w_head;
  assign w_rise      = ~r_lrck_q & bus.i_adclrck;
  assign w_arm       = bus.i_en & (w_fall | w_rise);
  assign w_wait_done = w_fall | w_rise;
  assign w_fifo_din  = {r_push_chan, r_push_sample};
  assign w_head      = fifo_entry_t'(w_fifo_dout);
  assign w_head_sample = w_head.sample;
  assign bus.o_chan  = ~w_empty & w_head.chan;
`else
  assign w_arm       = bus.i_en & w_fall;
  assign w_wait_done = bus.i_adclrck;
  assign w_fifo_din  = r_push_sample;
  assign w_head_sample = sample_t'(w_fifo_dout);
  assign bus.o_chan  = 1'b0;
`endif

  // The edge that releases S_WAIT may itself arm the next word (stereo);
  // in mono w_arm is always low while LRCK is high, so this falls to S_IDLE.
  always_ff @(posedge i_bclk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_lrck_q      <= 1'b0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_push        <= 1'b0;
      r_push_sample <= '0;
`ifdef AUD_REC_STEREO_EN
      r_chan        <= 1'b0;
      r_push_chan   <= 1'b0;
`endif
    end else begin
      r_lrck_q <= bus.i_adclrck;
      r_push   <= 1'b0;
      case (r_state)
        S_IDLE: if (w_arm) begin
          r_state <= S_SKIP;
`ifdef AUD_REC_STEREO_EN
          r_chan  <= bus.i_adclrck;
`endif
        end
        S_SKIP: begin
          r_state   <= S_RECEIVE;
          r_bit_cnt <= '0;
        end
        S_RECEIVE: begin
          r_shift   <= w_word[SAMPLE_W-2:0];
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == CNT_W'(SAMPLE_W-1)) begin
            r_push        <= 1'b1;
            r_push_sample <= w_word;
`ifdef AUD_REC_STEREO_EN
            r_push_chan   <= r_chan;
`endif
            r_state       <= S_WAIT;
          end
        end
        S_WAIT: if (w_wait_done) begin
          r_state <= w_arm ? S_SKIP : S_IDLE;
`ifdef AUD_REC_STEREO_EN
          r_chan  <= bus.i_adclrck;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_pop  = bus.i_ready & ~w_empty;
  assign w_drop = r_push & w_full & ~w_pop;

  always_ff @(posedge i_bclk) begin
    if (i_rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  aud_sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_bclk),
    .i_rst   (i_rst),
    .i_push  (r_push),
    .i_din   (w_fifo_din),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // Stale RAM contents never leak out while the FIFO is empty.
  assign bus.o_data     = w_empty ? '0 : w_head_sample;
  assign bus.o_valid    = ~w_empty;
  assign bus.o_level    = w_level;
  assign bus.o_overflow = r_overflow;
  assign bus.o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_aud_recorder.sv
// Randomized I2S capture bench: an edge-indexed capture/queue model predicts
// every output each cycle, plus literal checks on directed scenarios.
module tb_aud_recorder;
  import aud_pkg::*;

  localparam int DEPTH = 8;
  localparam int HMAX  = 16384;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aud_recorder_if #(.FIFO_DEPTH(DEPTH), .DROP_CNT_W(8)) bus();
  aud_recorder #(.FIFO_DEPTH(DEPTH), .DROP_CNT_W(8)) dut (
    .i_bclk (clk),
    .i_rst  (rst),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // model state: edge index t, input history, pending capture, output queue
  int          t = 0;
  bit          lh [HMAX];
  bit          dh [HMAX];
  logic        sv [HMAX];
  logic [15:0] sdat [HMAX];
  bit          busy = 0;
  bit          prev_l = 0;
  int          arm_at = -1;
  int          push_at = -1;
  logic [15:0] push_word;
  logic [15:0] q[$];
  bit          m_ovf = 0;
  int          m_cnt = 0;
  logic [15:0] popped[$];
  int          frame_t0 = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %h expected %h", nm, t, got, exp);
    end
  endtask

  // one bclk: check outputs after the previous edge, drive, advance model
  task automatic step(input bit l, input bit d, input bit e, input bit r, input bit rs);
    bit pop;
    logic [15:0] cw;
    @(negedge clk);
    if (t > 0) begin
      sv[t-1]   = bus.o_valid;
      sdat[t-1] = $unsigned(bus.o_data);
      chk("valid", 32'(bus.o_valid), 32'(q.size() != 0));
      chk("data",  32'($unsigned(bus.o_data)), (q.size() != 0) ? 32'(q[0]) : 32'd0);
      chk("level", 32'(bus.o_level), 32'(q.size()));
      chk("overflow", 32'(bus.o_overflow), 32'(m_ovf));
      chk("drop_cnt", 32'(bus.o_drop_cnt), 32'(m_cnt));
      chk("chan", 32'(bus.o_chan), 32'd0);
      if (r && bus.o_valid) popped.push_back($unsigned(bus.o_data));
    end
    bus.i_adclrck = l;
    bus.i_adcdat  = d;
    bus.i_en      = e;
    bus.i_ready   = r;
    rst           = rs;
    if (rs) begin
      q.delete();
      m_ovf = 0; m_cnt = 0; busy = 0; push_at = -1; prev_l = 0;
    end else begin
      lh[t] = l; dh[t] = d;
      pop = r && (q.size() != 0);
      if (pop) void'(q.pop_front());
      if (t == push_at) begin
        if (q.size() < DEPTH) q.push_back(push_word);
        else begin
          m_ovf = 1;
          if (m_cnt < 255) m_cnt++;
        end
      end
      if (busy && t == arm_at + 17) begin
        for (int i = 0; i < 16; i++) cw[15-i] = dh[arm_at+2+i];
        push_word = cw;
        push_at   = t + 1;
      end
      if (busy && t >= arm_at + 18 && l) busy = 0;
      else if (!busy && prev_l && !l && e) begin
        busy = 1; arm_at = t;
      end
      prev_l = l;
    end
    t++;
  endtask

  // rmode: 0 ready low, 1 ready high, 2 random, 3 high only at push edge
  task automatic send_frame(input logic [15:0] w, input bit en0, input int en_off_k,
                            input int rmode, input int rst_k, input int lo, input int hi);
    bit d, e, r;
    frame_t0 = t;
    for (int k = 0; k < lo; k++) begin
      d = (k >= 2 && k < 18) ? w[17-k] : 1'($urandom);
      e = (en_off_k >= 0 && k >= en_off_k) ? 1'b0 : en0;
      r = (rmode == 1) || (rmode == 2 && ($urandom % 3 == 0)) || (rmode == 3 && k == 18);
      step(1'b0, d, e, r, k == rst_k);
    end
    for (int k = lo; k < lo + hi; k++) begin
      e = (en_off_k >= 0) ? 1'b0 : en0;
      r = (rmode == 1) || (rmode == 2 && ($urandom % 3 == 0)) || (rmode == 3 && k == 18);
      step(1'b1, 1'($urandom), e, r, 1'b0);
    end
  endtask

  task automatic settle();
    @(posedge clk); #1;
  endtask

  logic [15:0] ow [10];
  logic [15:0] w10;
  logic [15:0] exp_drain [8];

  initial begin
    bus.i_adclrck = 1'b1; bus.i_adcdat = 1'b0; bus.i_en = 1'b0; bus.i_ready = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    chk("reset_valid", 32'(bus.o_valid), 32'd0);
    chk("reset_level", 32'(bus.o_level), 32'd0);
    chk("reset_data",  32'($unsigned(bus.o_data)), 32'd0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // single word: visible exactly one cycle, 18 edges after the fall
    send_frame(16'hA5C3, 1'b1, -1, 1, -1, 32, 32);
    chk("a5c3_pre",   32'(sv[frame_t0+17]), 32'd0);
    chk("a5c3_valid", 32'(sv[frame_t0+18]), 32'd1);
    chk("a5c3_data",  32'(sdat[frame_t0+18]), 32'h0000A5C3);
    chk("a5c3_post",  32'(sv[frame_t0+19]), 32'd0);

    // overflow: 10 words into 8 entries
    for (int i = 0; i < 10; i++) begin
      ow[i] = 16'($urandom);
      send_frame(ow[i], 1'b1, -1, 0, -1, 32, 32);
    end
    settle();
    chk("ovf_level", 32'(bus.o_level), 32'd8);
    chk("ovf_flag",  32'(bus.o_overflow), 32'd1);
    chk("ovf_drops", 32'(bus.o_drop_cnt), 32'd2);

    // full FIFO, pop coincident with push
    w10 = 16'h8001;
    send_frame(w10, 1'b1, -1, 3, -1, 32, 32);
    settle();
    chk("fullpop_level", 32'(bus.o_level), 32'd8);
    chk("fullpop_drops", 32'(bus.o_drop_cnt), 32'd2);

    // drain
    popped.delete();
    send_frame(16'h0, 1'b0, -1, 1, -1, 32, 32);
    for (int i = 0; i < 7; i++) exp_drain[i] = ow[i+1];
    exp_drain[7] = w10;
    chk("drain_count", 32'(popped.size()), 32'd8);
    for (int i = 0; i < 8 && i < popped.size(); i++)
      chk("drain_order", 32'(popped[i]), 32'(exp_drain[i]));

    // reset mid-word; overflow/drop must clear too
    send_frame(16'hFFFF, 1'b1, -1, 1, 9, 32, 32);
    chk("midrst_valid", 32'(sv[frame_t0+9]), 32'd0);
    send_frame(16'h3C5A, 1'b1, -1, 0, -1, 32, 32);
    settle();
    chk("postrst_level", 32'(bus.o_level), 32'd1);
    chk("postrst_data",  32'($unsigned(bus.o_data)), 32'h00003C5A);
    chk("postrst_ovf",   32'(bus.o_overflow), 32'd0);

    // enable dropped after bit 3: word completes, next fall is not armed
    send_frame(16'h0F0F, 1'b1, 6, 0, -1, 32, 32);
    send_frame(16'h7777, 1'b0, -1, 0, -1, 32, 32);
    settle();
    chk("endrop_level", 32'(bus.o_level), 32'd2);

    // mid-word LRCK fall is ignored
    send_frame(16'h1357, 1'b1, -1, 1, -1, 10, 3);
    send_frame(16'h2468, 1'b1, -1, 1, -1, 32, 32);

    // random frames
    for (int i = 0; i < 24; i++) begin
      if ($urandom % 6 == 0)
        send_frame(16'($urandom), 1'b1, -1, 2, -1, 10, 3);
      else
        send_frame(16'($urandom), ($urandom % 4) != 0,
                   ($urandom % 3 == 0) ? int'($urandom_range(17, 2)) : -1, 2, -1, 32, 32);
    end

    // drop counter saturation with tight frames
    for (int i = 0; i < 270; i++) send_frame(16'($urandom), 1'b1, -1, 0, -1, 18, 2);
    settle();
    chk("sat_drops", 32'(bus.o_drop_cnt), 32'd255);
    chk("sat_ovf",   32'(bus.o_overflow), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
